// File: rtl/sram_req_ctrl.sv
// rtl/sram_req_ctrl.sv - Request controller for one single-port SRAM macro with byte-mask read-modify-write
//
// Purpose: accepts one read or masked write at a time, drives a single-port
// registered SRAM macro that has no byte enables, and returns one response per
// request. Partial-mask writes become a read, a merge and a full-word write.
//
// Ports:
//   clock, reset           single clock, synchronous active-high reset
//   req_valid/req_ready    request handshake
//   req_wen                1 = write, 0 = read
//   req_addr/req_wdata     word address and write data
//   req_wmask              byte enables for writes (bit i -> byte i)
//   resp_valid/resp_ready  response handshake
//   resp_rdata             read data, or the word finally stored by a write
//   sram_ceb/sram_web      macro enable (active low) and write-enable (0 = write)
//   sram_a/sram_d/sram_q   macro address, write data, registered read data
module sram_req_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 64,
  parameter int MASK_W = DATA_W / 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [MASK_W-1:0] req_wmask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              sram_ceb,
  output logic              sram_web,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q
);

  // RESP is part of the encoding but the controller parks a finished response
  // in resp_valid_q while sitting in IDLE, so that a response handshake and the
  // next acceptance can share a cycle. RESP therefore only falls back to IDLE.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_CAP  = 3'd1,
    RMW_CAP = 3'd2,
    RMW_WR  = 3'd3,
    RESP    = 3'd4
  } state_e;

  state_e              state_q;
  logic                resp_valid_q;
  logic [DATA_W-1:0]   resp_rdata_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [MASK_W-1:0]   mask_q;
  logic [DATA_W-1:0]   merged_q;
  logic [DATA_W-1:0]   merged_d;

  logic accept;
  logic mask_full;
  logic mask_zero;

  assign req_ready  = !reset && (state_q == IDLE) && (!resp_valid_q || resp_ready);
  assign accept     = req_valid && req_ready;
  assign mask_full  = &req_wmask;
  assign mask_zero  = ~|req_wmask;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;

  // Byte merge of the saved write data over the word read back from the macro.
  // Only registered in RMW_CAP, the one cycle sram_q holds the RMW read.
  always_comb begin
    merged_d = sram_q;
    for (int i = 0; i < MASK_W; i++) begin
      if (mask_q[i]) begin
        merged_d[i*8 +: 8] = wdata_q[i*8 +: 8];
      end
    end
  end

  // The first access of a request is issued combinationally in the acceptance
  // cycle; only the RMW write-back comes from saved state. Reset forces the
  // macro idle so an aborted RMW never writes.
  always_comb begin
    sram_ceb = 1'b1;
    sram_web = 1'b1;
    sram_a   = '0;
    sram_d   = '0;
    if (!reset) begin
      if (accept && !(req_wen && mask_zero)) begin
        sram_ceb = 1'b0;
        sram_a   = req_addr;
        if (req_wen && mask_full) begin
          sram_web = 1'b0;
          sram_d   = req_wdata;
        end
      end else if (state_q == RMW_WR) begin
        sram_ceb = 1'b0;
        sram_web = 1'b0;
        sram_a   = addr_q;
        sram_d   = merged_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mask_q       <= '0;
      merged_q     <= '0;
    end else begin
      // A load below overrides this clear in the same cycle.
      if (resp_valid_q && resp_ready) begin
        resp_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (!req_wen) begin
              state_q <= RD_CAP;
            end else if (mask_full || mask_zero) begin
              resp_valid_q <= 1'b1;
              resp_rdata_q <= mask_full ? req_wdata : '0;
            end else begin
              addr_q  <= req_addr;
              wdata_q <= req_wdata;
              mask_q  <= req_wmask;
              state_q <= RMW_CAP;
            end
          end
        end
        RD_CAP: begin
          resp_valid_q <= 1'b1;
          resp_rdata_q <= sram_q;
          state_q      <= IDLE;
        end
        RMW_CAP: begin
          merged_q <= merged_d;
          state_q  <= RMW_WR;
        end
        RMW_WR: begin
          resp_valid_q <= 1'b1;
          resp_rdata_q <= merged_q;
          state_q      <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_req_ctrl.sv
// tb/tb_sram_req_ctrl.sv - Self-checking bench for sram_req_ctrl against a behavioural memory model
module tb_sram_req_ctrl;

  localparam int AW = 9;
  localparam int DW = 64;
  localparam int MW = 8;
  localparam int DEPTH = 512;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_wen = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [MW-1:0] req_wmask = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [DW-1:0] resp_rdata;
  logic          sram_ceb;
  logic          sram_web;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q = '0;

  always #5 clock = ~clock;

  sram_req_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .sram_ceb   (sram_ceb),
    .sram_web   (sram_web),
    .sram_a     (sram_a),
    .sram_d     (sram_d),
    .sram_q     (sram_q)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // SRAM macro: registered read, Q only meaningful the cycle after a read.
  logic [DW-1:0] init_mem [DEPTH];
  logic [DW-1:0] mem [DEPTH];
  bit            mem_loaded = 1'b0;

  always @(posedge clock) begin
    if (!mem_loaded) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_mem[i];
      mem_loaded <= 1'b1;
    end else if (!sram_ceb && !sram_web) begin
      mem[sram_a] <= sram_d;
    end
    if (!sram_ceb && sram_web) sram_q <= mem[sram_a];
    else                       sram_q <= {$urandom, $urandom};
  end

  // Reference model: word memory updated in acceptance order, one expected
  // response (data, arrival cycle, number of macro enables) per request.
  logic [DW-1:0] ref_mem [DEPTH];
  bit            ref_loaded = 1'b0;
  bit            pend = 1'b0;
  bit            pend_partial = 1'b0;
  int            pend_cyc = 0;
  int            pend_ceb = 0;
  logic [DW-1:0] pend_rd = '0;
  logic [AW-1:0] undo_a = '0;
  logic [DW-1:0] undo_d = '0;
  int            cyc = 0;
  int            ceb_cnt = 0;
  int            ceb_total = 0;
  bit            prev_hold = 1'b0;
  logic [DW-1:0] prev_rd = '0;
  bit            last_acc = 1'b0;
  bit            new_vis;
  bit            exp_ready;
  int            lat;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [MW-1:0] m);
    logic [DW-1:0] r;
    for (int i = 0; i < MW; i++) r[i*8 +: 8] = m[i] ? wd[i*8 +: 8] : old[i*8 +: 8];
    return r;
  endfunction

  always @(negedge clock) begin
    cyc++;
    last_acc = 1'b0;
    if (!ref_loaded) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_mem[i];
      ref_loaded = 1'b1;
    end
    if (reset) begin
      chk("reset_ceb", sram_ceb, 1);
      chk("reset_req_ready", req_ready, 0);
      if (pend && pend_partial) ref_mem[undo_a] = undo_d;
      pend = 1'b0;
      prev_hold = 1'b0;
      ceb_cnt = 0;
    end else begin
      new_vis = resp_valid && !prev_hold;
      if (prev_hold) begin
        chk("hold_resp_valid", resp_valid, 1);
        chk("hold_resp_rdata", resp_rdata, prev_rd);
      end
      if (pend && cyc == pend_cyc) begin
        chk("resp_at_latency", new_vis, 1);
        if (new_vis) begin
          chk("resp_rdata", resp_rdata, pend_rd);
          chk("ceb_cycles", ceb_cnt, pend_ceb);
        end
        pend = 1'b0;
        ceb_cnt = 0;
      end else if (new_vis) begin
        chk("unexpected_resp_valid", resp_valid, 0);
      end
      if (sram_ceb) begin
        chk("idle_web", sram_web, 1);
        chk("idle_a", sram_a, 0);
        chk("idle_d", sram_d, 0);
      end else begin
        ceb_cnt++;
        ceb_total++;
      end
      exp_ready = !pend && !(resp_valid && !resp_ready);
      chk("req_ready", req_ready, exp_ready);
      if (req_valid && req_ready) begin
        last_acc = 1'b1;
        pend = 1'b1;
        pend_partial = 1'b0;
        if (!req_wen) begin
          pend_rd = ref_mem[req_addr];
          lat = 2;
          pend_ceb = 1;
        end else if (req_wmask == 8'hFF) begin
          pend_rd = req_wdata;
          ref_mem[req_addr] = req_wdata;
          lat = 1;
          pend_ceb = 1;
        end else if (req_wmask == 8'h00) begin
          pend_rd = '0;
          lat = 1;
          pend_ceb = 0;
        end else begin
          undo_a = req_addr;
          undo_d = ref_mem[req_addr];
          pend_rd = merge(ref_mem[req_addr], req_wdata, req_wmask);
          ref_mem[req_addr] = pend_rd;
          pend_partial = 1'b1;
          lat = 3;
          pend_ceb = 2;
        end
        pend_cyc = cyc + lat;
      end
      prev_hold = resp_valid && !resp_ready;
      prev_rd = resp_rdata;
    end
  end

  task automatic issue(input bit wen, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [MW-1:0] m, input bit rr);
    int n;
    bit got;
    @(posedge clock); #1;
    req_valid = 1'b1; req_wen = wen; req_addr = a; req_wdata = wd; req_wmask = m;
    resp_ready = rr;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clock);
      n++;
      got = req_ready;
    end
    chk("accept_within_bound", got, 1);
  endtask

  task automatic wait_resp(input logic [DW-1:0] exp_rd, input int exp_lat);
    int n;
    bit got;
    @(posedge clock); #1;
    req_valid = 1'b0;
    req_addr  = AW'($urandom);
    req_wdata = {$urandom, $urandom};
    req_wmask = MW'($urandom);
    req_wen   = 1'($urandom);
    n = 1; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clock);
      got = resp_valid;
      if (!got) n++;
    end
    chk("resp_seen", got, 1);
    chk("resp_latency_literal", n, exp_lat);
    chk("resp_rdata_literal", resp_rdata, exp_rd);
  endtask

  task automatic run_op(input bit wen, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [MW-1:0] m, input logic [DW-1:0] exp_rd,
                        input int exp_lat, input int exp_ceb);
    int c0;
    c0 = ceb_total;
    issue(wen, a, wd, m, 1'b1);
    wait_resp(exp_rd, exp_lat);
    @(posedge clock); #1;
    chk("ceb_count_literal", ceb_total - c0, exp_ceb);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int nmis;
    logic [MW-1:0] m;
    for (int i = 0; i < DEPTH; i++) init_mem[i] = {$urandom, $urandom};

    repeat (3) begin
      @(negedge clock);
      chk("reset_resp_valid", resp_valid, 0);
      chk("reset_resp_rdata", resp_rdata, 0);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("ready_after_reset", req_ready, 1);

    // full write then read
    run_op(1'b1, 9'h005, 64'h1122334455667788, 8'hFF, 64'h1122334455667788, 1, 1);
    run_op(1'b0, 9'h005, 64'h0, 8'h00, 64'h1122334455667788, 2, 1);
    // partial write (low four bytes) then read
    run_op(1'b1, 9'h005, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 64'h11223344AAAAAAAA, 3, 2);
    run_op(1'b0, 9'h005, 64'h0, 8'h00, 64'h11223344AAAAAAAA, 2, 1);
    // zero-mask write leaves memory alone
    run_op(1'b1, 9'h010, 64'h0123456789ABCDEF, 8'hFF, 64'h0123456789ABCDEF, 1, 1);
    run_op(1'b1, 9'h010, 64'hFFFFFFFFFFFFFFFF, 8'h00, 64'h0, 1, 0);
    run_op(1'b0, 9'h010, 64'h0, 8'h00, 64'h0123456789ABCDEF, 2, 1);

    // response backpressure on a read of the top address
    run_op(1'b1, 9'h1FF, 64'hDEADBEEFCAFEF00D, 8'hFF, 64'hDEADBEEFCAFEF00D, 1, 1);
    issue(1'b0, 9'h1FF, 64'h0, 8'h00, 1'b0);
    wait_resp(64'hDEADBEEFCAFEF00D, 2);
    repeat (5) begin
      @(posedge clock); #1;
      @(negedge clock);
      chk("stall_resp_valid", resp_valid, 1);
      chk("stall_resp_rdata", resp_rdata, 64'hDEADBEEFCAFEF00D);
      chk("stall_req_ready", req_ready, 0);
      chk("stall_ceb", sram_ceb, 1);
    end
    issue(1'b0, 9'h005, 64'h0, 8'h00, 1'b1);
    chk("b2b_resp_handshake", resp_valid && resp_ready, 1);
    wait_resp(64'h11223344AAAAAAAA, 2);

    // reset during the RMW write-back cycle
    issue(1'b1, 9'h005, 64'h5555555555555555, 8'hF0, 1'b1);
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("rmw_reset_ceb", sram_ceb, 1);
    chk("rmw_reset_req_ready", req_ready, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("post_reset_resp_valid", resp_valid, 0);
    chk("post_reset_req_ready", req_ready, 1);
    run_op(1'b0, 9'h005, 64'h0, 8'h00, 64'h11223344AAAAAAAA, 2, 1);

    // random back-to-back traffic with random response backpressure
    for (int c = 0; c < 600; c++) begin
      @(posedge clock); #1;
      if (!req_valid || last_acc) begin
        req_valid = ($urandom_range(0, 9) < 7);
        req_wen   = 1'($urandom_range(0, 1));
        req_addr  = AW'($urandom_range(0, 15));
        req_wdata = {$urandom, $urandom};
        case ($urandom_range(0, 3))
          0:       m = 8'hFF;
          1:       m = 8'h00;
          default: m = MW'($urandom);
        endcase
        req_wmask = m;
      end
      resp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clock); #1;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    repeat (10) @(negedge clock);
    chk("drain_nothing_pending", pend, 0);

    nmis = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) nmis++;
    chk("final_mem_words_differing", nmis, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
